// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 Hz raster timing defaults, derived totals, sync
//            window bounds, colour bit positions and a range helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Counter width: pixel_addr carries x and y at this width each
    localparam int CNT_W  = 11;
    localparam int ADDR_W = 2 * CNT_W;

    // Horizontal timing in pixel ticks
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    // Vertical timing in lines
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Derived totals (800 ticks per line, 525 lines per frame)
    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Inclusive sync windows (656..751 and 490..491)
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Colour bit positions inside pixel_data = {R,G,B}
    localparam int COLOR_R_BIT = 2;
    localparam int COLOR_G_BIT = 1;
    localparam int COLOR_B_BIT = 0;

    // True when lo <= val <= hi
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_raster_counter
// Brief    : Tick-enabled horizontal/vertical raster counters with wrap.
//            line_end / frame_end flag the last position of a line / frame.
// Revision : 1.0 - initial release
// ============================================================================
module vga_raster_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] c_h_last = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_v_last = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    assign line_end  = (h_cnt == c_h_last);
    assign frame_end = line_end && (v_cnt == c_v_last);

    // Advance the raster position once per pixel tick, wrapping line then frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= frame_end ? '0 : (v_cnt + c_one);
            end else begin
                h_cnt <= h_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out
// Brief    : VGA display output stage. Generates the pixel fetch address,
//            samples the returned colour and drives RGB / HS / VS through a
//            two-tick pipeline so sync and colour stay phase-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_out
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [2:0]        pixel_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              VGA_R,
    output logic              VGA_G,
    output logic              VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] c_h_vis      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] c_v_vis      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic             r_tick;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_unused_line_end;
    logic             w_frame_end;

    // Stage A qualifier: counters currently sit at (0,0)
    logic             r_a_sof;
    // Stage B registers
    logic             r_vis_d;
    logic             r_hs_d;
    logic             r_vs_d;
    logic             r_b_sof;

    // Divide sysclk by two to form the pixel-rate enable
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
        end
    end

    // Stage A: raster position counters (sync decode works directly on h/v,
    // so only the frame wrap flag is consumed here)
    vga_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk       (sysclk),
        .rst       (rst),
        .tick      (r_tick),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .line_end  (w_unused_line_end),
        .frame_end (w_frame_end)
    );

    // Track origin of Stage A; reset leaves the counters at (0,0)
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_a_sof <= 1'b1;
        end else if (r_tick) begin
            r_a_sof <= w_frame_end;
        end
    end

    // Stage B: publish fetch address and decode visibility / sync
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            r_vis_d    <= 1'b0;
            r_hs_d     <= 1'b1;
            r_vs_d     <= 1'b1;
            r_b_sof    <= 1'b0;
        end else if (r_tick) begin
            pixel_addr <= {w_v_cnt, w_h_cnt};
            r_vis_d    <= (w_h_cnt < c_h_vis) && (w_v_cnt < c_v_vis);
            r_hs_d     <= !in_range(w_h_cnt, c_hs_start, c_hs_end);
            r_vs_d     <= !in_range(w_v_cnt, c_vs_start, c_vs_end);
            r_b_sof    <= r_a_sof;
        end
    end

    // Stage C: drive pins; colour gated to black outside the visible area.
    // frame_start is set only on the pixel-tick edge, so it lasts one sysclk.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            VGA_R       <= 1'b0;
            VGA_G       <= 1'b0;
            VGA_B       <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= r_tick && r_b_sof;
            if (r_tick) begin
                VGA_R  <= r_vis_d && pixel_data[COLOR_R_BIT];
                VGA_G  <= r_vis_d && pixel_data[COLOR_G_BIT];
                VGA_B  <= r_vis_d && pixel_data[COLOR_B_BIT];
                VGA_HS <= r_hs_d;
                VGA_VS <= r_vs_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_out
// Brief    : Self-checking bench for vga_scan_out on a reduced raster
//            (32x19 ticks) using an independent position model and a queue
//            of expected pin values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_out;

    localparam int HV  = 16;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HB  = 6;
    localparam int VV  = 12;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int LINE_CLKS  = 2 * HT;
    localparam int FRAME_CLKS = 2 * HT * VT;

    logic        sysclk = 1'b0;
    logic        rst    = 1'b1;
    logic        mode   = 1'b0;
    logic [2:0]  pixel_data;
    logic [21:0] pixel_addr;
    logic        vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start;

    vga_scan_out #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .pixel_data  (pixel_data),
        .pixel_addr  (pixel_addr),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .frame_start (frame_start)
    );

    always #5 sysclk = ~sysclk;

    // Switcher model: constant magenta, or x mod 8 of the fetched address
    assign pixel_data = mode ? pixel_addr[2:0] : 3'b101;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } pins_t;

    pins_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   cyc = 0;
    int   mx = 0;
    int   my = 0;
    int   hs_fall = -1;
    int   vs_fall = -1;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   fs_count = 0;
    int   fs_first = -1;
    int   fs_second = -1;
    int   rel_cyc = 0;
    int   guard = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Restart the position model right after rst is released
    task automatic release_model();
        exp_q.delete();
        edge_n    = 0;
        mx        = 0;
        my        = 0;
        hs_fall   = -1;
        vs_fall   = -1;
        prev_hs   = 1'b1;
        prev_vs   = 1'b1;
        fs_first  = -1;
        fs_second = -1;
        rel_cyc   = cyc;
    endtask

    // One sysclk: sample 1 ns after the edge, measure sync timing, and on
    // pixel-tick edges pop the expected pins and push the next expectation
    task automatic step();
        pins_t       e;
        logic [10:0] x11;
        logic [10:0] y11;
        @(posedge sysclk);
        #1;
        edge_n++;
        cyc++;
        if (frame_start) begin
            fs_count++;
            if (fs_first < 0)       fs_first = cyc;
            else if (fs_second < 0) fs_second = cyc;
        end
        if (prev_hs && !vga_hs) begin
            if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, LINE_CLKS);
            hs_fall = cyc;
        end
        if (!prev_hs && vga_hs && hs_fall >= 0) chk("hs_low_width", cyc - hs_fall, 2 * HSW);
        if (prev_vs && !vga_vs) begin
            if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, FRAME_CLKS);
            vs_fall = cyc;
        end
        if (!prev_vs && vga_vs && vs_fall >= 0) chk("vs_low_width", cyc - vs_fall, VSW * LINE_CLKS);
        prev_hs = vga_hs;
        prev_vs = vga_vs;

        if (edge_n % 2 == 0) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '{3'b000, 1'b1, 1'b1, 1'b0};
            chk("rgb", {vga_r, vga_g, vga_b}, e.rgb);
            chk("hs", vga_hs, e.hs);
            chk("vs", vga_vs, e.vs);
            chk("frame_start", frame_start, e.fs);

            x11 = mx[10:0];
            y11 = my[10:0];
            chk("pixel_addr", pixel_addr, {y11, x11});
            e.fs  = (mx == 0) && (my == 0);
            e.hs  = !((mx >= HV + HF) && (mx < HV + HF + HSW));
            e.vs  = !((my >= VV + VF) && (my < VV + VF + VSW));
            e.rgb = ((mx < HV) && (my < VV)) ? (mode ? x11[2:0] : 3'b101) : 3'b000;
            exp_q.push_back(e);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end else begin
            chk("frame_start_width", frame_start, 0);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_addr", pixel_addr, 0);
        chk("reset_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("reset_hs", vga_hs, 1);
        chk("reset_vs", vga_vs, 1);
        chk("reset_fs", frame_start, 0);

        // Two frames of solid 3'b101
        @(negedge sysclk);
        rst = 1'b0;
        release_model();
        repeat (2 * FRAME_CLKS) step();
        chk("fs_count_solid", fs_count, 2);
        chk("fs_first_latency", fs_first - rel_cyc, 4);
        chk("fs_interval", fs_second - fs_first, FRAME_CLKS);

        // Two frames of x mod 8 (mode flips while only blank pixels are queued)
        mode = 1'b1;
        repeat (2 * FRAME_CLKS) step();
        chk("fs_count_xmod8", fs_count, 4);

        // Run into line 8 so the pins sit inside the horizontal sync pulse
        guard = 0;
        while (!(my == 8 && mx == 22) && guard < FRAME_CLKS) begin
            step();
            guard++;
        end
        chk("reach_mid_frame", guard < FRAME_CLKS, 1);
        chk("hs_low_before_rst", vga_hs, 0);

        // Mid-frame asynchronous reset for 3 sysclk
        @(negedge sysclk);
        rst = 1'b1;
        #1;
        chk("async_rst_hs", vga_hs, 1);
        chk("async_rst_vs", vga_vs, 1);
        chk("async_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("async_rst_addr", pixel_addr, 0);
        chk("async_rst_fs", frame_start, 0);
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_hold_addr", pixel_addr, 0);
        @(negedge sysclk);
        rst = 1'b0;
        release_model();
        repeat (2 * FRAME_CLKS + 8) step();
        chk("fs_after_rst_first", fs_first - rel_cyc, 4);
        chk("fs_after_rst_window",
            (fs_second - rel_cyc >= FRAME_CLKS - 4) && (fs_second - rel_cyc <= FRAME_CLKS + 4), 1);
        chk("fs_after_rst_interval", fs_second - fs_first, FRAME_CLKS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
